vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock.
- Drives the hCount/vCount/bright inputs of the pixel-colouring/game stage and the hSync/vSync pins of the VGA connector.
- Counter coordinates include sync and back porch: visible region is hCount 144..783 and vCount 35..514.
- Also provides a pixel-rate enable and a once-per-frame pulse, so downstream game logic can step once per frame instead of using free-running dividers.

Parameters:
- CLK_DIV, 4: system clocks per pixel; must be >= 1.
- H_SYNC, 96: hsync pulse width in pixels.
- H_BP, 48: horizontal back porch in pixels.
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch in pixels.
- V_SYNC, 2: vsync pulse width in lines.
- V_BP, 33: vertical back porch in lines.
- V_VIS, 480: visible lines per frame.
- V_FP, 10: vertical front porch in lines.

Ports:
- clk, in, 1: system clock, 100 MHz.
- reset_n, in, 1: asynchronous, active-low reset.
- hCount, out, 10: horizontal pixel counter, 0..H_TOTAL-1.
- vCount, out, 10: vertical line counter, 0..V_TOTAL-1.
- hSync, out, 1: horizontal sync, active low.
- vSync, out, 1: vertical sync, active low.
- bright, out, 1: high while (hCount, vCount) is in the visible region.
- pix_en, out, 1: one-clk pulse each time the counters advance.
- frame_start, out, 1: one-clk pulse when the counters advance to (0,0).

Behaviour:
- Interface (already decided): one clock, clk; reset_n is asynchronous and active-low.
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_VIS+H_FP = 800.
  - V_TOTAL = V_SYNC+V_BP+V_VIS+V_FP = 525.
  - H_START = H_SYNC+H_BP = 144.
  - V_START = V_SYNC+V_BP = 35.
- Reset: while reset_n is low, all of the following are 0 immediately, without waiting for a clock edge:
  - the internal divider, hCount and vCount;
  - hSync and vSync (position 0 lies in the sync region);
  - bright, pix_en and frame_start.
- Divider:
  - On each posedge clk, if div == CLK_DIV-1: div <= 0 and this is an advance cycle.
  - Otherwise div <= div+1.
  - pix_en is registered high for exactly the clk following an advance edge; otherwise low.
  - With CLK_DIV=1 every edge is an advance edge, so pix_en stays high continuously after the first edge.
- Counters, updated on advance edges only:
  - If hCount == H_TOTAL-1: hCount <= 0, and vCount <= (vCount == V_TOTAL-1) ? 0 : vCount+1.
  - Otherwise hCount <= hCount+1 and vCount holds.
- Sync and bright:
  - hSync, vSync and bright are registered.
  - They are computed from the next counter values, so they are always consistent with hCount/vCount in the same cycle (zero relative latency).
  - hSync = 0 iff hCount < H_SYNC.
  - vSync = 0 iff vCount < V_SYNC.
  - bright = 1 iff H_START <= hCount <= H_START+H_VIS-1 and V_START <= vCount <= V_START+V_VIS-1.
- frame_start is high for the one clk in which the counters newly equal (0,0) after a wrap. It is not asserted after reset release.
- First advance after reset release is on the CLK_DIV-th rising edge; hCount becomes 1.
- Period: line = H_TOTAL*CLK_DIV clks = 3200; frame = 525 lines = 1,680,000 clks.
- Arithmetic:
  - All counters are unsigned.
  - Comparisons are done at the 10-bit counter width.
  - The divider is $clog2(CLK_DIV)+1 bits wide; no overflow is possible with legal parameters.

Test Plan:
- Reset/start: hold reset_n=0 for 10 clks, then release -> all outputs 0 during reset; on the 4th rising edge after release hCount=1 and pix_en=1 for 1 clk; frame_start stays 0.
- Horizontal: run one line -> hSync=0 for hCount 0..95 and 1 for 96..799; after hCount=799 the next value is 0 and vCount increments by 1; line length is exactly 3200 clks.
- Vertical/frame: run 2 frames -> vSync=0 only for vCount 0..1; vCount wraps 524->0; frame_start pulses exactly once per 1,680,000 clks.
- Bright window: count pix_en cycles with bright=1 over one frame -> exactly 307200; bright=0 at (143,35), (784,35), (144,34) and (144,515); bright=1 at (144,35) and (783,514).
- Async reset mid-frame: drop reset_n between clock edges at hCount=500, vCount=200 -> all outputs 0 before the next edge; after release, counting restarts from (0,0) with the first advance 4 clks later.
- Parameter override CLK_DIV=1 -> pix_en stays high after the first edge; hCount advances every clk; line length is 800 clks.

Source files
------------

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60 VGA timing generator with pixel enable and frame pulse
module vga_sync_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV) + 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_LO = 10'(H_START);
  localparam logic [9:0] H_VIS_HI = 10'(H_START + H_VIS - 1);
  localparam logic [9:0] V_VIS_LO = 10'(V_START);
  localparam logic [9:0] V_VIS_HI = 10'(V_START + V_VIS - 1);

  logic [DW-1:0] div;
  logic          adv;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;

  always_comb begin
    adv   = (div == DIV_LAST);
    h_nxt = hCount;
    v_nxt = vCount;
    if (adv) begin
      if (hCount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vCount == V_LAST) ? '0 : vCount + 10'd1;
      end else begin
        h_nxt = hCount + 10'd1;
      end
    end
  end

  // Sync/bright are derived from the next counter values so they line up
  // with hCount/vCount in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div         <= '0;
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      pix_en      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= adv ? '0 : div + DW'(1);
      hCount      <= h_nxt;
      vCount      <= v_nxt;
      hSync       <= (h_nxt >= H_SYNC_W);
      vSync       <= (v_nxt >= V_SYNC_W);
      bright      <= (h_nxt >= H_VIS_LO) && (h_nxt <= H_VIS_HI) &&
                     (v_nxt >= V_VIS_LO) && (v_nxt <= V_VIS_HI);
      pix_en      <= adv;
      frame_start <= adv && (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen against an arithmetic timing model
module tb_vga_sync_gen;

  typedef logic [24:0] vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] hc_d, vc_d, hc_f, vc_f, hc_s, vc_s;
  logic hs_d, vs_d, br_d, pe_d, fs_d;
  logic hs_f, vs_f, br_f, pe_f, fs_f;
  logic hs_s, vs_s, br_s, pe_s, fs_s;

  vga_sync_gen u_def (
    .clk(clk), .reset_n(reset_n), .hCount(hc_d), .vCount(vc_d), .hSync(hs_d),
    .vSync(vs_d), .bright(br_d), .pix_en(pe_d), .frame_start(fs_d));

  vga_sync_gen #(.CLK_DIV(1)) u_fast (
    .clk(clk), .reset_n(reset_n), .hCount(hc_f), .vCount(vc_f), .hSync(hs_f),
    .vSync(vs_f), .bright(br_f), .pix_en(pe_f), .frame_start(fs_f));

  vga_sync_gen #(.CLK_DIV(2), .H_SYNC(3), .H_BP(2), .H_VIS(5), .H_FP(2),
                 .V_SYNC(2), .V_BP(2), .V_VIS(3), .V_FP(1)) u_small (
    .clk(clk), .reset_n(reset_n), .hCount(hc_s), .vCount(vc_s), .hSync(hs_s),
    .vSync(vs_s), .bright(br_s), .pix_en(pe_s), .frame_start(fs_s));

  int checks = 0;
  int errors = 0;
  int k = 0;
  vec_t q_def[$], q_fast[$], q_small[$];

  // Position is simply the number of pixel periods elapsed since reset release.
  function automatic vec_t model(input int kk, input int cd, input int hs, input int hbp,
                                 input int hvis, input int hfp, input int vs, input int vbp,
                                 input int vvis, input int vfp);
    int ht, vt, p, h, v;
    logic pe, fs, hsy, vsy, br;
    if (kk == 0) return '0;
    ht  = hs + hbp + hvis + hfp;
    vt  = vs + vbp + vvis + vfp;
    p   = (kk / cd) % (ht * vt);
    h   = p % ht;
    v   = p / ht;
    pe  = (kk % cd) == 0;
    fs  = pe && (p == 0);
    hsy = h >= hs;
    vsy = v >= vs;
    br  = (h >= hs + hbp) && (h < hs + hbp + hvis) && (v >= vs + vbp) && (v < vs + vbp + vvis);
    return {10'(h), 10'(v), hsy, vsy, br, pe, fs};
  endfunction

  task automatic check(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b br=%b pe=%b fs=%b, required h=%0d v=%0d hs=%b vs=%b br=%b pe=%b fs=%b",
               name, $time, act[24:15], act[14:5], act[4], act[3], act[2], act[1], act[0],
               exp[24:15], exp[14:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; reset changes land between edges (2 ns after posedge).
  task automatic step(input logic run);
    @(posedge clk);
    if (reset_n) k++;
    #2;
    if (!run) begin
      reset_n = 1'b0;
      k = 0;
    end else begin
      reset_n = 1'b1;
    end
    q_def.push_back(model(k, 4, 96, 48, 640, 16, 2, 33, 480, 10));
    q_fast.push_back(model(k, 1, 96, 48, 640, 16, 2, 33, 480, 10));
    q_small.push_back(model(k, 2, 3, 2, 5, 2, 2, 2, 3, 1));
  endtask

  int  len_d = 0, len_f = 0, len_s = 0, bright_s = 0;
  bit  have_d = 0, have_f = 0, have_s = 0;

  always @(negedge clk) begin
    if (q_def.size() > 0) begin
      check("def", {hc_d, vc_d, hs_d, vs_d, br_d, pe_d, fs_d}, q_def.pop_front());
      check("fast", {hc_f, vc_f, hs_f, vs_f, br_f, pe_f, fs_f}, q_fast.pop_front());
      check("small", {hc_s, vc_s, hs_s, vs_s, br_s, pe_s, fs_s}, q_small.pop_front());
    end
    len_d++; len_f++; len_s++;
    if (pe_s && br_s) bright_s++;
    if (!reset_n) begin
      have_d = 0; have_f = 0; have_s = 0;
    end else begin
      if (pe_d && hc_d == 10'd0) begin
        if (have_d) check_int("def_line_clks", len_d, 3200);
        len_d = 0; have_d = 1;
      end
      if (pe_f && hc_f == 10'd0) begin
        if (have_f) check_int("fast_line_clks", len_f, 800);
        len_f = 0; have_f = 1;
      end
      if (fs_s) begin
        if (have_s) begin
          check_int("small_frame_clks", len_s, 192);
          check_int("small_bright_pix", bright_s, 15);
        end
        len_s = 0; bright_s = 0; have_s = 1;
      end
    end
  end

  initial begin
    repeat (10) step(1'b0);
    repeat (10000) step(1'b1);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(50, 3000)) step(1'b1);
      repeat ($urandom_range(1, 4)) step(1'b0);
    end
    repeat (500) step(1'b1);
    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
